// File: rtl/zone_alarm_ctrl.sv
// rtl/zone_alarm_ctrl.sv - multi-zone debounced smoke/mains alarm controller (optional feature macro: ALARM_SELFTEST_EN)

module zone_alarm_debounce #(
  parameter int   DEB_CYCLES = 8,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);
  localparam int            CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // count consecutive disagreeing samples; adopt raw once DEB_CYCLES of them have been seen
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      filt <= RST_VAL;
    end else if (raw == filt) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      filt <= raw;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module zone_alarm_ctrl #(
  parameter int N_ZONES    = 4,
  parameter int DEB_CYCLES = 8,
  parameter int ESC_CYCLES = 1000
`ifdef ALARM_SELFTEST_EN
  ,
  parameter int TEST_CYCLES = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               corriente,
  input  logic [N_ZONES-1:0] humo,
  input  logic               ack,
`ifdef ALARM_SELFTEST_EN
  input  logic               test_req,
`endif
  output logic               alarma2,
  output logic               alarma3,
  output logic               luz_ok,
  output logic               luz_power,
  output logic [N_ZONES-1:0] luz_zone,
  output logic [2:0]         estado
);
  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_MONITOR    = 3'd1,
    S_ALARM      = 3'd2,
    S_ESCALATED  = 3'd3,
    S_SILENCED   = 3'd4,
    S_POWER_FAIL = 3'd5,
    S_TEST       = 3'd6
  } state_t;

  localparam int            EW       = $clog2(ESC_CYCLES);
  localparam logic [EW-1:0] ESC_LAST = EW'(ESC_CYCLES - 1);
`ifdef ALARM_SELFTEST_EN
  localparam int            TW       = (TEST_CYCLES > 1) ? $clog2(TEST_CYCLES) : 1;
  localparam logic [TW-1:0] TST_LAST = TW'(TEST_CYCLES - 1);
`endif

  logic [N_ZONES-1:0] humo_f;
  logic               corr_f;

  // mains input idles at "present" so a reset never reports a power fault
  zone_alarm_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_corr (
    .clk  (clk),
    .rst  (rst),
    .raw  (corriente),
    .filt (corr_f)
  );

  for (genvar i = 0; i < N_ZONES; i++) begin : g_deb
    zone_alarm_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_humo (
      .clk  (clk),
      .rst  (rst),
      .raw  (humo[i]),
      .filt (humo_f[i])
    );
  end

  state_t             state, state_nxt;
  logic [N_ZONES-1:0] latch, latch_nxt;
  logic [EW-1:0]      esc_cnt, esc_nxt;
  logic               pf_sil, pf_sil_nxt;
`ifdef ALARM_SELFTEST_EN
  logic [TW-1:0]      tst_cnt, tst_nxt;
`endif
  logic               any_smoke;
  logic               new_smoke;

  assign any_smoke = |humo_f;
  assign new_smoke = |(humo_f & ~latch);
  assign estado    = state;

  // next state, zone latches and counters from the current state and filtered inputs
  always_comb begin
    state_nxt  = state;
    latch_nxt  = latch;
    esc_nxt    = esc_cnt;
    pf_sil_nxt = pf_sil;
`ifdef ALARM_SELFTEST_EN
    tst_nxt    = tst_cnt;
`endif
    case (state)
      S_INIT: state_nxt = S_MONITOR;
      S_MONITOR: begin
        if (any_smoke) begin
          state_nxt = S_ALARM;
          latch_nxt = latch | humo_f;
          esc_nxt   = '0;
        end else if (!corr_f) begin
          state_nxt  = S_POWER_FAIL;
          pf_sil_nxt = 1'b0;
        end
`ifdef ALARM_SELFTEST_EN
        else if (test_req) begin
          state_nxt = S_TEST;
          tst_nxt   = '0;
        end
`endif
      end
      S_ALARM: begin
        latch_nxt = latch | humo_f;
        if (ack) begin
          state_nxt = S_SILENCED;
          esc_nxt   = '0;
        end else if (esc_cnt == ESC_LAST) begin
          state_nxt = S_ESCALATED;
        end else begin
          esc_nxt = esc_cnt + 1'b1;
        end
      end
      S_ESCALATED: begin
        latch_nxt = latch | humo_f;
        if (ack) begin
          state_nxt = S_SILENCED;
          esc_nxt   = '0;
        end
      end
      S_SILENCED: begin
        if (new_smoke) begin
          state_nxt = S_ALARM;
          latch_nxt = latch | humo_f;
          esc_nxt   = '0;
        end else if (!any_smoke) begin
          state_nxt = S_MONITOR;
          latch_nxt = '0;
        end
      end
      S_POWER_FAIL: begin
        if (any_smoke) begin
          state_nxt = S_ALARM;
          latch_nxt = latch | humo_f;
          esc_nxt   = '0;
        end else if (corr_f) begin
          state_nxt = S_MONITOR;
        end else if (ack) begin
          pf_sil_nxt = 1'b1;
        end
      end
`ifdef ALARM_SELFTEST_EN
      S_TEST: begin
        if (any_smoke) begin
          state_nxt = S_ALARM;
          latch_nxt = humo_f;
          esc_nxt   = '0;
        end else if (tst_cnt == TST_LAST) begin
          state_nxt = S_MONITOR;
          latch_nxt = '0;
        end else begin
          tst_nxt = tst_cnt + 1'b1;
        end
      end
`endif
      default: state_nxt = S_INIT;
    endcase
  end

  // state register; outputs are registered from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      latch     <= '0;
      esc_cnt   <= '0;
      pf_sil    <= 1'b0;
`ifdef ALARM_SELFTEST_EN
      tst_cnt   <= '0;
`endif
      alarma2   <= 1'b0;
      alarma3   <= 1'b0;
      luz_ok    <= 1'b0;
      luz_power <= 1'b0;
      luz_zone  <= '0;
    end else begin
      state     <= state_nxt;
      latch     <= latch_nxt;
      esc_cnt   <= esc_nxt;
      pf_sil    <= pf_sil_nxt;
`ifdef ALARM_SELFTEST_EN
      tst_cnt   <= tst_nxt;
`endif
      alarma2   <= (state_nxt == S_ALARM) || (state_nxt == S_ESCALATED) ||
                   (state_nxt == S_TEST) ||
                   ((state_nxt == S_POWER_FAIL) && !pf_sil_nxt);
      alarma3   <= (state_nxt == S_ESCALATED);
      luz_ok    <= (state_nxt == S_MONITOR);
      luz_power <= (state_nxt != S_INIT) && !corr_f;
      luz_zone  <= (state_nxt == S_TEST) ? {N_ZONES{1'b1}} : latch_nxt;
    end
  end
endmodule

// File: tb/tb_zone_alarm_ctrl.sv
// tb/tb_zone_alarm_ctrl.sv - self-checking bench for zone_alarm_ctrl
module tb_zone_alarm_ctrl;
  localparam int N   = 4;
  localparam int DEB = 8;
  localparam int ESC = 20;
  localparam int TST = 16;

  localparam int S_INIT = 0, S_MON = 1, S_ALM = 2, S_ESC = 3, S_SIL = 4, S_PF = 5, S_TEST = 6;

  logic         clk = 1'b0;
  logic         rst, corriente, ack;
  logic [N-1:0] humo;
`ifdef ALARM_SELFTEST_EN
  logic         test_req;
`endif
  logic         alarma2, alarma3, luz_ok, luz_power;
  logic [N-1:0] luz_zone;
  logic [2:0]   estado;
  logic [10:0]  act;

  always #5 clk = ~clk;

  zone_alarm_ctrl #(
    .N_ZONES(N), .DEB_CYCLES(DEB), .ESC_CYCLES(ESC)
`ifdef ALARM_SELFTEST_EN
    , .TEST_CYCLES(TST)
`endif
  ) dut (
    .clk(clk), .rst(rst), .corriente(corriente), .humo(humo), .ack(ack),
`ifdef ALARM_SELFTEST_EN
    .test_req(test_req),
`endif
    .alarma2(alarma2), .alarma3(alarma3), .luz_ok(luz_ok), .luz_power(luz_power),
    .luz_zone(luz_zone), .estado(estado)
  );

  assign act = {estado, alarma2, alarma3, luz_ok, luz_power, luz_zone};

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [10:0] a, input logic [10:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: actual est=%0d a2=%b a3=%b ok=%b pw=%b zone=%b, required est=%0d a2=%b a3=%b ok=%b pw=%b zone=%b",
               name, a[10:8], a[7], a[6], a[5], a[4], a[3:0], e[10:8], e[7], e[6], e[5], e[4], e[3:0]);
    end
  endtask

  // reference model: filtered inputs derived from the last DEB raw samples
  int           m_state, m_age, m_tage;
  bit           m_pfsil;
  logic [N-1:0] m_sf, m_latch;
  logic         m_cf;
  logic [31:0]  m_sh [N+1];
  int           m_nv [N+1];
  logic [10:0]  exp_v;

  task automatic model_step();
    logic [N-1:0] sf;
    logic         cf, r, f, a2;
    logic [31:0]  mask;
    logic [N-1:0] zone;
    if (rst) begin
      m_state = S_INIT; m_sf = '0; m_cf = 1'b1; m_latch = '0;
      m_age = 0; m_tage = 0; m_pfsil = 0;
      for (int c = 0; c <= N; c++) begin m_sh[c] = '0; m_nv[c] = 0; end
      exp_v = '0;
    end else begin
      sf = m_sf; cf = m_cf;
      case (m_state)
        S_INIT: m_state = S_MON;
        S_MON: begin
          if (sf != 0) begin m_state = S_ALM; m_latch |= sf; m_age = 0; end
          else if (!cf) begin m_state = S_PF; m_pfsil = 0; end
`ifdef ALARM_SELFTEST_EN
          else if (test_req) begin m_state = S_TEST; m_tage = 0; end
`endif
        end
        S_ALM: begin
          m_latch |= sf;
          if (ack) m_state = S_SIL;
          else begin
            m_age++;
            if (m_age == ESC) m_state = S_ESC;
          end
        end
        S_ESC: begin
          m_latch |= sf;
          if (ack) m_state = S_SIL;
        end
        S_SIL: begin
          if ((sf & ~m_latch) != 0) begin m_state = S_ALM; m_latch |= sf; m_age = 0; end
          else if (sf == 0) begin m_state = S_MON; m_latch = '0; end
        end
        S_PF: begin
          if (sf != 0) begin m_state = S_ALM; m_latch |= sf; m_age = 0; end
          else if (cf) m_state = S_MON;
          else if (ack) m_pfsil = 1;
        end
`ifdef ALARM_SELFTEST_EN
        S_TEST: begin
          if (sf != 0) begin m_state = S_ALM; m_latch = sf; m_age = 0; end
          else begin
            m_tage++;
            if (m_tage == TST) begin m_state = S_MON; m_latch = '0; end
          end
        end
`endif
        default: m_state = S_INIT;
      endcase
      mask = (32'h1 << DEB) - 32'h1;
      for (int c = 0; c <= N; c++) begin
        r = (c < N) ? humo[c] : corriente;
        f = (c < N) ? m_sf[c] : m_cf;
        m_sh[c] = {m_sh[c][30:0], r};
        if (m_nv[c] < DEB) m_nv[c]++;
        if (m_nv[c] >= DEB && (m_sh[c] & mask) == (f ? 32'h0 : mask)) begin
          if (c < N) m_sf[c] = ~f;
          else m_cf = ~f;
        end
      end
      a2 = (m_state == S_ALM) || (m_state == S_ESC) || (m_state == S_TEST) ||
           (m_state == S_PF && !m_pfsil);
      zone = (m_state == S_TEST) ? {N{1'b1}} : m_latch;
      exp_v = {3'(m_state), a2, (m_state == S_ESC), (m_state == S_MON),
               (m_state != S_INIT) && !cf, zone};
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      chk("model", act, exp_v);
    end
  endtask

  typedef struct {
    int         n;
    logic       rst, corr;
    logic [3:0] humo;
    logic       ack;
    logic [2:0] est;
    logic       a2, a3, ok, pw;
    logic [3:0] zone;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic r, input logic c, input logic [3:0] h, input logic a,
                     input logic [2:0] est, input logic a2, input logic a3, input logic ok,
                     input logic pw, input logic [3:0] zone);
    vec_t v;
    v.n = n; v.rst = r; v.corr = c; v.humo = h; v.ack = a;
    v.est = est; v.a2 = a2; v.a3 = a3; v.ok = ok; v.pw = pw; v.zone = zone;
    tbl.push_back(v);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rst = tbl[i].rst; corriente = tbl[i].corr; humo = tbl[i].humo; ack = tbl[i].ack;
      tick(tbl[i].n);
      chk($sformatf("vec%0d", i), act,
          {tbl[i].est, tbl[i].a2, tbl[i].a3, tbl[i].ok, tbl[i].pw, tbl[i].zone});
    end
  endtask

  initial begin
    logic [N-1:0] hold;
    logic         chold;
    int           mark1, gi;
    rst = 1'b1; corriente = 1'b1; humo = '0; ack = 1'b0;
`ifdef ALARM_SELFTEST_EN
    test_req = 1'b0;
`endif
    //   n  rst corr humo     ack  est a2 a3 ok pw zone
    add( 2, 1, 1, 4'b0000, 0, 3'd0, 0, 0, 0, 0, 4'b0000);   // reset
    add( 1, 0, 1, 4'b0000, 0, 3'd1, 0, 0, 1, 0, 4'b0000);   // INIT -> MONITOR
    add( 1, 0, 1, 4'b0000, 1, 3'd1, 0, 0, 1, 0, 4'b0000);   // ack ignored
    add( 7, 0, 1, 4'b0010, 0, 3'd1, 0, 0, 1, 0, 4'b0000);   // 7-cycle glitch
    add( 1, 0, 1, 4'b0000, 0, 3'd1, 0, 0, 1, 0, 4'b0000);
    add( 8, 0, 1, 4'b0010, 0, 3'd1, 0, 0, 1, 0, 4'b0000);   // filtered flips
    add( 1, 0, 1, 4'b0010, 0, 3'd2, 1, 0, 0, 0, 4'b0010);   // ALARM
    add(19, 0, 1, 4'b0010, 0, 3'd2, 1, 0, 0, 0, 4'b0010);
    add( 1, 0, 1, 4'b0010, 0, 3'd3, 1, 1, 0, 0, 4'b0010);   // escalated at 20
    add( 1, 0, 1, 4'b0010, 1, 3'd4, 0, 0, 0, 0, 4'b0010);   // silenced
    add( 8, 0, 1, 4'b1010, 0, 3'd4, 0, 0, 0, 0, 4'b0010);
    add( 1, 0, 1, 4'b1010, 0, 3'd2, 1, 0, 0, 0, 4'b1010);   // new zone
    mark1 = tbl.size();
    add( 8, 0, 1, 4'b0000, 0, 3'd4, 0, 0, 0, 0, 4'b1010);
    add( 1, 0, 1, 4'b0000, 0, 3'd1, 0, 0, 1, 0, 4'b0000);   // back to MONITOR
    add( 8, 0, 0, 4'b0000, 0, 3'd1, 0, 0, 1, 0, 4'b0000);   // power loss
    add( 1, 0, 0, 4'b0000, 0, 3'd5, 1, 0, 0, 1, 4'b0000);
    add( 1, 0, 0, 4'b0000, 1, 3'd5, 0, 0, 0, 1, 4'b0000);   // ack silences siren
    add( 8, 0, 1, 4'b0000, 0, 3'd5, 0, 0, 0, 1, 4'b0000);
    add( 1, 0, 1, 4'b0000, 0, 3'd1, 0, 0, 1, 0, 4'b0000);
    add( 8, 0, 0, 4'b0001, 0, 3'd1, 0, 0, 1, 0, 4'b0000);   // simultaneous events
    add( 1, 0, 0, 4'b0001, 0, 3'd2, 1, 0, 0, 1, 4'b0001);
    add( 1, 0, 0, 4'b0001, 1, 3'd4, 0, 0, 0, 1, 4'b0001);
    add( 8, 0, 1, 4'b0000, 0, 3'd4, 0, 0, 0, 1, 4'b0001);
    add( 1, 0, 1, 4'b0000, 0, 3'd1, 0, 0, 1, 0, 4'b0000);
    add( 8, 0, 1, 4'b0100, 0, 3'd1, 0, 0, 1, 0, 4'b0000);   // reset mid-ESCALATED
    add( 1, 0, 1, 4'b0100, 0, 3'd2, 1, 0, 0, 0, 4'b0100);
    add(20, 0, 1, 4'b0100, 0, 3'd3, 1, 1, 0, 0, 4'b0100);
    add( 1, 1, 1, 4'b0000, 1, 3'd0, 0, 0, 0, 0, 4'b0000);
    add( 1, 0, 1, 4'b0000, 0, 3'd1, 0, 0, 1, 0, 4'b0000);

    run_vecs(0, mark1);
    // ack arriving on the escalation terminal cycle must win
    humo = 4'b1010;
    for (int k = 0; k < ESC - 1; k++) begin
      tick(1);
      chk("esc_wait", act, {3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010});
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("ack_tc", act, {3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010});
    run_vecs(mark1, tbl.size());

`ifdef ALARM_SELFTEST_EN
    test_req = 1'b1;
    tick(1);
    test_req = 1'b0;
    chk("test_enter", act, {3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111});
    tick(TST - 1);
    chk("test_hold", act, {3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111});
    tick(1);
    chk("test_exit", act, {3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000});
`endif

    hold = '0;
    chold = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      for (int z = 0; z < N; z++) begin
        if (hold[z]) begin
          if ($urandom_range(19) == 0) hold[z] = 1'b0;
        end else if ($urandom_range(149) == 0) hold[z] = 1'b1;
      end
      if ($urandom_range(199) == 0) chold = ~chold;
      humo = hold;
      if ($urandom_range(24) == 0) begin
        gi = $urandom_range(N - 1);
        humo[gi] = ~humo[gi];
      end
      corriente = chold ^ ($urandom_range(39) == 0);
      ack = ($urandom_range(15) == 0);
      rst = ($urandom_range(799) == 0);
`ifdef ALARM_SELFTEST_EN
      test_req = ($urandom_range(99) == 0);
`endif
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule

// File: doc/zone_alarm_ctrl.md
Name: zone_alarm_ctrl

Overview:
- Parametrised multi-zone successor to the single-channel mains/smoke alarm FSM.
- Monitors one mains-current-present input and N_ZONES smoke inputs.
- Every input passes through a debounce filter.
- Drives a latched, acknowledgeable, escalating alarm plus per-zone indicator lights.
- Sits between the sensor input synchronisers and the siren/LED drivers.

Parameters:
N_ZONES, 4, number of smoke zones (1..16)
DEB_CYCLES, 8, consecutive cycles a raw input must differ from its filtered value before the filtered value flips (>=1)
ESC_CYCLES, 1000, cycles in ALARM without ack before escalation (>=2)
TEST_CYCLES, 16, self-test alarm duration (used only with ALARM_SELFTEST_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
corriente  in  1  mains current present (1 = OK), already synchronised
humo  in  N_ZONES  raw smoke detect per zone, already synchronised
ack  in  1  operator acknowledge, single-cycle pulse
alarma2  out  1  primary alarm (siren)
alarma3  out  1  escalated alarm
luz_ok  out  1  system armed and healthy
luz_power  out  1  mains fault indicator
luz_zone  out  N_ZONES  latched zone-in-alarm lights
estado  out  3  current FSM state code, for debug

Behaviour:
- Reset, clocked by clk while rst=1:
  - FSM enters INIT.
  - All outputs 0.
  - Filtered smoke = 0; filtered corriente = 1.
  - Debounce, escalation and test counters = 0; zone latches = 0.
- Debounce, per input, independent:
  - Counter increments while raw != filtered; clears when raw == filtered.
  - When the counter reaches DEB_CYCLES-1 and raw still differs, filtered takes raw on that edge and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes filtered.
  - Latency from a stable input change to the filtered change: exactly DEB_CYCLES cycles.
- State codes: INIT=0, MONITOR=1, ALARM=2, ESCALATED=3, SILENCED=4, POWER_FAIL=5, TEST=6.
- INIT: outputs 0; unconditional transition to MONITOR next cycle.
- MONITOR:
  - luz_ok=1.
  - Any filtered smoke bit set -> ALARM; OR those bits into the zone latches.
  - Else filtered corriente=0 -> POWER_FAIL.
  - Smoke has priority over power on simultaneous events.
- ALARM:
  - alarma2=1.
  - Escalation counter increments every cycle and keeps ORing newly filtered zones into the latches.
  - ack=1 -> SILENCED; counter clears.
  - Else counter == ESC_CYCLES-1 -> ESCALATED.
  - ack has priority over escalation in the same cycle.
- ESCALATED:
  - alarma2=1, alarma3=1; latches continue to accumulate.
  - ack -> SILENCED.
- SILENCED:
  - alarma2=alarma3=0; latches held.
  - A filtered smoke bit set whose latch is 0 -> ALARM, set that latch, escalation counter restarts at 0.
  - All filtered smoke = 0 -> MONITOR, all latches clear on that edge.
- POWER_FAIL:
  - luz_power=1, alarma2=1.
  - Filtered smoke set -> ALARM (luz_power stays 1 while filtered corriente=0).
  - Filtered corriente=1 -> MONITOR.
  - ack silences alarma2 only; luz_power stays on and the state does not change.
- Output timing:
  - luz_zone = zone latches in every state.
  - All outputs are registered and update on the edge that enters the state; no combinational input-to-output paths.
  - luz_power = NOT filtered corriente, in all states except INIT.
- Reset asserted mid-operation: the next edge forces the full reset values regardless of state, counters or pending ack.
- ack outside ALARM/ESCALATED/POWER_FAIL is ignored.

Optional Feature:
ALARM_SELFTEST_EN
- Defined:
  - Adds input port test_req (1 bit).
  - In MONITOR with no filtered smoke and filtered corriente=1, test_req=1 -> TEST.
  - TEST: alarma2=1, luz_zone all ones for TEST_CYCLES cycles, then -> MONITOR with latches cleared.
  - Filtered smoke during TEST -> ALARM immediately, latching only the real zones.
- Undefined: no test_req port, TEST state unreachable, code 6 never produced.

Test Plan:
- Glitch rejection: rst 2 cycles, humo=4'b0010 held 7 cycles with DEB_CYCLES=8 -> estado stays 1, alarma2=0. Hold 8 cycles -> estado=2, alarma2=1, luz_zone=4'b0010 on the following edge.
- Escalation: ESC_CYCLES=20, smoke held, no ack -> alarma3 rises exactly 20 cycles after entering ALARM. Then ack -> estado=4, alarma2=alarma3=0, luz_zone retained.
- New zone while silenced: in SILENCED with zone 1 latched, zone 3 smoke filtered -> ALARM, luz_zone=4'b1010, counter restarted. All smoke cleared after ack -> MONITOR, luz_zone=0.
- Power fail: corriente=0 for 8 cycles -> estado=5, luz_power=1, alarma2=1. ack -> alarma2=0, luz_power=1. corriente=1 for 8 cycles -> estado=1.
- Simultaneous: smoke zone 0 and corriente loss filter on the same cycle -> ALARM with luz_power=1. ack and the escalation terminal count on the same cycle -> SILENCED, alarma3 never asserted.
- Reset mid-ESCALATED: rst pulse 1 cycle -> all outputs 0, estado=0, then 1 on the next cycle. With ALARM_SELFTEST_EN: test_req pulse -> 16 cycles alarma2=1, luz_zone=4'b1111, then MONITOR.
